// File: rtl/exp_stream_driver.sv
// Purpose:      ramp stimulus generator and result collector wrapped around the exp() Taylor core.
// Latency:      o_valid rises 1 cycle after an accepted i_start; each core result lands in the FWFT FIFO 1 cycle after its receive transfer.
// Backpressure: o_ready = !fifo_full stalls the core; o_valid is withheld unless a FIFO slot is reserved for every in-flight sample.
//
// Ports: clk/reset (async, active-low); i_start/i_x_start/i_x_step/i_count start a run;
//        o_x/o_valid/i_ready form the core input handshake; i_y/i_valid/o_ready form the core output handshake;
//        o_res_data/o_res_valid/i_res_pop form the host FIFO read side; o_busy/o_done/o_recv_cnt/o_timeout report status.
// Build option: define EXP_DRV_TIMEOUT_EN to enable the watchdog (o_timeout); otherwise o_timeout is tied 0.
module exp_stream_driver #(
  parameter int WIDTHIN    = 16,
  parameter int WIDTHOUT   = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [WIDTHIN-1:0]  i_x_start,
  input  logic [WIDTHIN-1:0]  i_x_step,
  input  logic [CNT_W-1:0]    i_count,
  output logic [WIDTHIN-1:0]  o_x,
  output logic                o_valid,
  input  logic                i_ready,
  input  logic [WIDTHOUT-1:0] i_y,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [WIDTHOUT-1:0] o_res_data,
  output logic                o_res_valid,
  input  logic                i_res_pop,
  output logic                o_busy,
  output logic                o_done,
  output logic [CNT_W-1:0]    o_recv_cnt,
  output logic                o_timeout
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FC_W  = AW + 1;
  localparam int SUM_W = ((CNT_W > FC_W) ? CNT_W : FC_W) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_cfg_check
    $error("exp_stream_driver: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTHIN-1:0] x_q, x_d, step_q, step_d;
  logic [CNT_W-1:0]   count_q, count_d, sent_q, sent_d, recv_q, recv_d;
  logic               valid_q, valid_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [FC_W-1:0]    fcnt_q, fcnt_d;
  logic [WIDTHOUT-1:0] mem_q [FIFO_DEPTH];

  logic               send_xfer, recv_xfer, pop, in_run;
  logic [CNT_W-1:0]   inflight_d;
  logic [SUM_W-1:0]   occ_d;

`ifdef EXP_DRV_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    step_d  = step_q;
    count_d = count_q;
    sent_d  = sent_q;
    recv_d  = recv_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
`ifdef EXP_DRV_TIMEOUT_EN
    wd_d    = wd_q;
    to_d    = to_q;
`endif

    in_run    = (state_q == S_SEND) || (state_q == S_DRAIN);
    send_xfer = valid_q & i_ready;
    // Results outside a run, or beyond the requested count, are dropped.
    recv_xfer = i_valid & ready_q & in_run & (recv_q != count_q);
    pop       = i_res_pop & (fcnt_q != '0);

    if (send_xfer) begin
      sent_d = sent_q + 1'b1;
      x_d    = x_q + step_q;
    end
    if (recv_xfer) begin
      recv_d = recv_q + 1'b1;
      wr_d   = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    fcnt_d = fcnt_q + FC_W'(recv_xfer) - FC_W'(pop);

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          x_d     = i_x_start;
          step_d  = i_x_step;
          count_d = i_count;
          sent_d  = '0;
          recv_d  = '0;
`ifdef EXP_DRV_TIMEOUT_EN
          wd_d    = '0;
          to_d    = 1'b0;
`endif
          state_d = (i_count == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND:  if (sent_d == count_q) state_d = S_DRAIN;
      S_DRAIN: if (recv_d == count_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

`ifdef EXP_DRV_TIMEOUT_EN
    // Count only cycles where the core owes us a result and none arrives.
    if (in_run) begin
      if (recv_xfer || (sent_q == recv_q)) begin
        wd_d = '0;
      end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
        wd_d    = '0;
        to_d    = 1'b1;
        state_d = S_DONE;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif

    // Gate on next-cycle occupancy: every in-flight sample holds a FIFO slot,
    // so once o_valid is raised the sum can only shrink and o_valid can hold.
    inflight_d = sent_d - recv_d;
    occ_d      = SUM_W'(inflight_d) + SUM_W'(fcnt_d);
    valid_d    = (state_d == S_SEND) && (sent_d != count_d) && (occ_d < SUM_W'(FIFO_DEPTH));
    ready_d    = (fcnt_d != FC_W'(FIFO_DEPTH));
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      step_q  <= '0;
      count_q <= '0;
      sent_q  <= '0;
      recv_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      fcnt_q  <= '0;
`ifdef EXP_DRV_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      step_q  <= step_d;
      count_q <= count_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fcnt_q  <= fcnt_d;
`ifdef EXP_DRV_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  // Storage needs no reset: entries are only visible while fcnt_q covers them.
  always_ff @(posedge clk) begin
    if (recv_xfer) mem_q[wr_q] <= i_y;
  end

  assign o_x         = x_q;
  assign o_valid     = valid_q;
  assign o_ready     = ready_q;
  assign o_res_valid = (fcnt_q != '0);
  assign o_res_data  = o_res_valid ? mem_q[rd_q] : '0;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_recv_cnt  = recv_q;
`ifdef EXP_DRV_TIMEOUT_EN
  assign o_timeout   = to_q;
`else
  assign o_timeout   = 1'b0;
`endif

endmodule
